// File: rtl/latency_memory_model_pkg.sv
// Shared types for the block-oriented simulation memory and its latency counter.
// Block geometry, FSM state encoding and the per-operation latency selector.
package latency_memory_model_pkg;

    localparam int BLOCKS    = 4;
    localparam int BLOCK_OFF = $clog2(BLOCKS * 4);

    typedef logic [BLOCKS-1:0][31:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_e;

    function automatic int unsigned op_latency(input logic we, input int unsigned rd_lat,
                                               input int unsigned wr_lat);
        return we ? wr_lat : rd_lat;
    endfunction

endpackage

// File: rtl/latency_memory_model_latency_ctr.sv
// Latency counter: counts cycles since request acceptance, flags the cycle before completion.
// Latency: done is combinational from the count; load/clear take effect on the next edge.
// Backpressure: none; the owning FSM decides when to load, hold or clear.
module latency_ctr #(
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [CW-1:0] target,
    output logic          done,
    output logic          busy
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // The acceptance cycle is cycle 0, so the first waiting cycle carries a count of 1.
    assign done = busy_q && ((cnt_q + CW'(1)) == (target - CW'(1)));
    assign busy = busy_q;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (clear) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/latency_memory_model.sv
// Block-granular simulation memory with independent read/write latency and op counters.
// Latency: completion L-1 cycles after acceptance (L=1 completes in the acceptance cycle).
// Backpressure: mem_miss held high while busy; requester holds mem_req until the low cycle.
module latency_memory_model #(
    parameter int BLOCKS     = latency_memory_model_pkg::BLOCKS,
    parameter int RAM_WORDS  = 4096,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 4,
    parameter int INIT_MODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_req,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_we,
    input  logic [BLOCKS*32-1:0]  mem_write_block,
    output logic [BLOCKS*32-1:0]  mem_read_block,
    output logic                  mem_miss,
    output logic                  mem_err,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);
    import latency_memory_model_pkg::*;

    localparam int OFF  = $clog2(BLOCKS * 4);
    localparam int IW   = 32 - OFF;
    localparam int AW   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int NBLK = RAM_WORDS / BLOCKS;
    localparam int CW   = 16;

    mem_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [31:0]   rd_count_q, rd_count_d;
    logic [31:0]   wr_count_q, wr_count_d;
    logic [31:0]   mem_q [RAM_WORDS];

    logic          changed, accept, cmpl, cmpl_we, oor, wr_en;
    logic          ld, ctr_clear, ctr_done, ctr_busy;
    int unsigned   lat_new;
    logic [CW-1:0] lat_cur;
    logic [IW-1:0] cur_idx;
    logic [31:0]   base_word;
    logic [AW-1:0] base;
    logic [BLOCKS*32-1:0] rd_blk;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[OFF-1:0];
    assign lat_cur = CW'(op_latency(we_q, RD_LATENCY, WR_LATENCY));

    latency_ctr #(.CW(CW)) u_ctr (
        .clock  (clock),
        .reset  (reset),
        .load   (ld),
        .clear  (ctr_clear),
        .target (lat_cur),
        .done   (ctr_done),
        .busy   (ctr_busy)
    );

    // A live request with a new block or direction re-accepts from scratch; a dropped one aborts.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        mem_miss = 1'b0;
        cmpl     = 1'b0;
        cmpl_we  = we_q;
        cur_idx  = idx_q;
        ld       = 1'b0;
        changed  = (idx_q != mem_addr[31:OFF]) || (we_q != mem_we);
        lat_new  = op_latency(mem_we, RD_LATENCY, WR_LATENCY);
        accept   = mem_req && ((state_q == IDLE) || changed);
        if (accept) begin
            idx_d = mem_addr[31:OFF];
            we_d  = mem_we;
            if (lat_new == 1) begin
                cmpl    = 1'b1;
                cmpl_we = mem_we;
                cur_idx = mem_addr[31:OFF];
                state_d = IDLE;
            end else begin
                mem_miss = 1'b1;
                ld       = (lat_new > 2);
                state_d  = ld ? WAIT : DONE;
            end
        end else if (!mem_req) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                WAIT: begin
                    mem_miss = ctr_busy;
                    if (ctr_done) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    cmpl    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        ctr_clear = !ld && (state_d != WAIT);
        if (reset) begin
            mem_miss = 1'b0;
            cmpl     = 1'b0;
        end
    end

    always_comb begin
        oor       = ({{OFF{1'b0}}, cur_idx} >= 32'(NBLK));
        base_word = 32'(cur_idx) << $clog2(BLOCKS);
        base      = base_word[AW-1:0];
        wr_en     = cmpl && cmpl_we && !oor;
        rd_blk    = '0;
        for (int i = 0; i < BLOCKS; i++) begin
            rd_blk[i*32 +: 32] = mem_q[base + AW'(i)];
        end
    end

    assign mem_read_block = (cmpl && !cmpl_we && !oor) ? rd_blk : '0;
    assign mem_err        = cmpl && oor;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (cmpl && !cmpl_we && (rd_count_q != 32'hFFFF_FFFF)) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (cmpl && cmpl_we && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            we_q       <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Write data is sampled on the same edge that closes the completion cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                mem_q[i] <= (INIT_MODE == 0) ? (32'(i) << 2) : 32'd0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < BLOCKS; i++) begin
                mem_q[base + AW'(i)] <= mem_write_block[i*32 +: 32];
            end
        end
    end

endmodule
